alu_pipe: RTL and testbench

Two-stage pipelined successor to the team's combinational WIDTH-bit ALU. It keeps the same opcode space and Z/N/C/O flag semantics, and adds:
- XOR and arithmetic-right-shift opcodes
- valid/ready handshakes on input and output, with full throughput under backpressure
- a carry-chained mode (add/sub with carry) for multi-word arithmetic
- a sticky overflow flag

It sits between the operand-issue logic and the writeback buffer of the datapath.

---
 rtl/alu_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU. S1 captures an accepted operation. S2 computes result and flags
// during the S1->S2 transfer and holds them under valid/ready backpressure.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_ctrl,
   input  logic             carry_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             O,
   input  logic             clr_sticky,
   output logic             sticky_O
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SLL = 3'b100,
      OP_SRL = 3'b101,
      OP_XOR = 3'b110,
      OP_SRA = 3'b111
   } op_e;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_e              s1_op;
   logic             s1_cen;
   logic             cf;

   logic             s1_move;
   logic             accept;

   assign s1_move  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s1_move;
   assign accept   = in_valid && in_ready;

   // S1 occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (s1_move) begin
         s1_valid <= 1'b0;
      end
   end

   // NOTE: the S1 payload has no reset; s1_valid qualifies it, so garbage after reset is never used.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a   <= a;
         s1_b   <= b;
         s1_op  <= op_e'(alu_ctrl);
         s1_cen <= carry_en;
      end
   end

   logic             is_sub;
   logic             is_arith;
   logic             cin;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] calc_res;
   logic             calc_c;
   logic             calc_o;

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can infer a latch.
      calc_res = '0;
      calc_c   = 1'b0;
      calc_o   = 1'b0;
      is_sub   = (s1_op == OP_SUB);
      is_arith = (s1_op == OP_ADD) || is_sub;
      b_eff    = is_sub ? ~s1_b : s1_b;
      // A chained op takes its carry-in from cf; otherwise SUB needs +1 to complete two's complement.
      cin      = s1_cen ? cf : is_sub;
      sum      = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      shamt    = s1_b[SHW-1:0];
      case (s1_op)
         OP_ADD, OP_SUB: begin
            calc_res = sum[WIDTH-1:0];
            calc_c   = sum[WIDTH];
            calc_o   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_AND: calc_res = s1_a & s1_b;
         OP_OR:  calc_res = s1_a | s1_b;
         OP_XOR: calc_res = s1_a ^ s1_b;
         OP_SLL: calc_res = s1_a << shamt;
         OP_SRL: calc_res = s1_a >> shamt;
         OP_SRA: calc_res = $signed(s1_a) >>> shamt;
      endcase
   end

   // S2 output register, carry chain and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         Z         <= 1'b1;
         N         <= 1'b0;
         C         <= 1'b0;
         O         <= 1'b0;
         cf        <= 1'b0;
         sticky_O  <= 1'b0;
      end else begin
         if (s1_move) begin
            out_valid <= 1'b1;
            result    <= calc_res;
            Z         <= (calc_res == '0);
            N         <= calc_res[WIDTH-1];
            C         <= calc_c;
            O         <= calc_o;
            if (is_arith) begin
               cf <= calc_c;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // A new overflow beats a simultaneous clear.
         if (s1_move && calc_o) begin
            sticky_O <= 1'b1;
         end else if (clr_sticky) begin
            sticky_O <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: fixed vectors with hand-computed results, a carry chain,
// a backpressured stream against a small model, mid-flight reset and sticky overflow.
module tb_alu_pipe;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] SLL = 3'b100;
   localparam logic [2:0] SRL = 3'b101;
   localparam logic [2:0] XOR = 3'b110;
   localparam logic [2:0] SRA = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [2:0]  alu_ctrl = '0;
   logic        carry_en = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        Z, N, C, O;
   logic        clr_sticky = 1'b0;
   logic        sticky_O;

   int          n_vec = 0;
   int          n_err = 0;
   logic [35:0] mon_q[$];
   logic [35:0] exp_q[$];
   logic        m_cf = 1'b0;

   alu_pipe #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .alu_ctrl   (alu_ctrl),
      .carry_en   (carry_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .Z          (Z),
      .N          (N),
      .C          (C),
      .O          (O),
      .clr_sticky (clr_sticky),
      .sticky_O   (sticky_O)
   );

   always #5 clk = ~clk;

   // Records every delivered output, sampled just before the edge that transfers it.
   always @(negedge clk) begin
      #4;
      if (rst_n && out_valid && out_ready) mon_q.push_back({result, Z, N, C, O});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: signed overflow from 64-bit range checks, carry from 64-bit unsigned sums.
   task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic cen, output logic [35:0] r);
      logic [31:0] res;
      logic        c, o, ci;
      longint      u, s;
      int          sh;
      res = '0;
      c   = 1'b0;
      o   = 1'b0;
      sh  = int'(y[4:0]);
      case (op)
         ADD: begin
            ci  = cen ? m_cf : 1'b0;
            u   = longint'(x) + longint'(y) + longint'(ci);
            s   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            res = u[31:0];
            c   = u[32];
            o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_cf = c;
         end
         SUB: begin
            ci  = cen ? m_cf : 1'b1;
            u   = longint'(x) + (64'hFFFF_FFFF - longint'(y)) + longint'(ci);
            s   = longint'($signed(x)) - longint'($signed(y)) - 1 + longint'(ci);
            res = u[31:0];
            c   = u[32];
            o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            m_cf = c;
         end
         AND: res = x & y;
         OR:  res = x | y;
         XOR: res = x ^ y;
         SLL: res = x << sh;
         SRL: res = x >> sh;
         SRA: res = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      endcase
      r = {res, (res == 32'h0), res[31], c, o};
   endtask

   // Offers one op starting at a falling edge; returns on the falling edge after acceptance.
   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic cen);
      logic acc;
      acc      = 1'b0;
      alu_ctrl = op;
      a        = x;
      b        = y;
      carry_en = cen;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         #3;
         acc = in_ready;
         @(negedge clk);
      end
      check("issue accepted", acc, 1'b1);
   endtask

   // One isolated op with out_ready high: checks latency and the delivered value.
   task automatic single(input string tag, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic cen, input logic [35:0] exp);
      issue(op, x, y, cen);
      in_valid = 1'b0;
      #3;
      check({tag, " lat1"}, out_valid, 1'b0);
      @(negedge clk);
      #3;
      check({tag, " lat2"}, out_valid, 1'b1);
      check(tag, {result, Z, N, C, O}, exp);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [35:0] exp);
      logic [35:0] got;
      got = '0;
      for (int i = 0; i < 50 && mon_q.size() == 0; i++) @(negedge clk);
      check({tag, " delivered"}, mon_q.size() > 0, 1'b1);
      if (mon_q.size() > 0) got = mon_q.pop_front();
      check(tag, got, exp);
   endtask

   initial begin
      logic [35:0] r;
      logic [36:0] held;
      logic        stall_prev;
      logic [2:0]  s_op;
      logic [31:0] s_a, s_b;
      logic        s_cen;
      int          i, n_acc, cyc, occ;

      // ---- reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst out_valid", out_valid, 1'b0);
      check("rst result/flags", {result, Z, N, C, O}, {32'h0, 4'b1000});
      check("rst sticky", sticky_O, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #3;
      check("rst in_ready", in_ready, 1'b1);
      @(negedge clk);

      // ---- basic arithmetic, logic, shifts
      single("add 10+20", ADD, 32'd10, 32'd20, 1'b0, {32'd30, 4'b0000});
      check("sticky clear before ovf", sticky_O, 1'b0);
      single("add ovf", ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, {32'h8000_0000, 4'b0101});
      check("sticky after ovf", sticky_O, 1'b1);
      single("sub 50-20", SUB, 32'd50, 32'd20, 1'b0, {32'd30, 4'b0010});
      single("sub ovf", SUB, 32'h8000_0000, 32'd1, 1'b0, {32'h7FFF_FFFF, 4'b0011});
      single("xor", XOR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, {32'h0000_FF00, 4'b0000});
      single("or", OR, 32'h0000_00F0, 32'h0000_0F00, 1'b0, {32'h0000_0FF0, 4'b0000});
      single("sra", SRA, 32'h8000_0000, 32'h0000_0024, 1'b0, {32'hF800_0000, 4'b0100});
      single("sll", SLL, 32'd1, 32'd4, 1'b0, {32'd16, 4'b0000});
      single("sll upper b ignored", SLL, 32'd1, 32'h0000_0021, 1'b0, {32'd2, 4'b0000});
      single("srl", SRL, 32'd32, 32'd2, 1'b0, {32'd8, 4'b0000});
      check("sticky held", sticky_O, 1'b1);

      // ---- back-to-back carry chain
      mon_q.delete();
      issue(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
      issue(AND, 32'h0000_FF00, 32'h0000_0F0F, 1'b0);
      issue(ADD, 32'd5, 32'd6, 1'b1);
      issue(SUB, 32'd0, 32'd1, 1'b0);
      issue(SUB, 32'd10, 32'd3, 1'b1);
      in_valid = 1'b0;
      expect_out("chain lo add", {32'h0, 4'b1010});
      expect_out("chain and", {32'h0000_0F00, 4'b0000});
      expect_out("chain hi adc", {32'd12, 4'b0000});
      expect_out("chain sub borrow", {32'hFFFF_FFFF, 4'b0100});
      expect_out("chain sbc", {32'd6, 4'b0010});
      repeat (3) @(negedge clk);

      // ---- backpressured stream of 20 ops
      mon_q.delete();
      exp_q.delete();
      m_cf       = 1'b0;
      i          = 0;
      n_acc      = 0;
      cyc        = 0;
      stall_prev = 1'b0;
      held       = '0;
      while (mon_q.size() < 20 && cyc < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         s_op  = 3'(i % 8);
         s_a   = 32'(32'h9E37_79B9 * 32'(i + 1));
         s_b   = (i % 5 == 0) ? 32'(i + 1) : ({s_a[15:0], s_a[31:16]} ^ 32'h00FF_00FF);
         s_cen = (i % 3 == 1);
         if (i < 20) begin
            alu_ctrl = s_op;
            a        = s_a;
            b        = s_b;
            carry_en = s_cen;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #3;
         if (stall_prev) check("stall hold", {out_valid, result, Z, N, C, O}, held);
         stall_prev = out_valid && !out_ready;
         held       = {out_valid, result, Z, N, C, O};
         occ        = n_acc - mon_q.size();
         check("in_ready vs occupancy", in_ready, !(occ == 2 && !out_ready));
         if (in_valid && in_ready) begin
            model(s_op, s_a, s_b, s_cen, r);
            exp_q.push_back(r);
            n_acc++;
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream delivered count", mon_q.size(), 20);
      for (int k = 0; k < 20; k++) begin
         if (k < mon_q.size() && k < exp_q.size()) check("stream item", mon_q[k], exp_q[k]);
      end
      repeat (3) @(negedge clk);

      // ---- reset with two ops in flight
      single("cf set", ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 4'b1010});
      out_ready = 1'b0;
      issue(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
      issue(SUB, 32'd5, 32'd1, 1'b0);
      in_valid = 1'b0;
      #1;
      check("full pipe in_ready", in_ready, 1'b0);
      check("full pipe out_valid", out_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst out_valid", out_valid, 1'b0);
      check("midrst result/flags", {result, Z, N, C, O}, {32'h0, 4'b1000});
      check("midrst sticky", sticky_O, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #3;
      check("post rst in_ready", in_ready, 1'b1);
      check("post rst empty", out_valid, 1'b0);
      @(negedge clk);
      single("adc after rst", ADD, 32'd1, 32'd1, 1'b1, {32'd2, 4'b0000});

      // ---- clr_sticky coinciding with an overflowing op entering S2
      clr_sticky = 1'b1;
      issue(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
      in_valid = 1'b0;
      #3;
      check("sticky before S2 entry", sticky_O, 1'b0);
      @(negedge clk);
      #3;
      check("sticky set beats clr", sticky_O, 1'b1);
      @(negedge clk);
      #3;
      check("sticky cleared", sticky_O, 1'b0);
      clr_sticky = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
